// File: rtl/dh_pkg.sv
// Shared types and constants for the modular-exponentiation cipher round.
package dh_pkg;

   localparam int DATA_W_D = 4;
   localparam int KEY_W_D  = 32;

   typedef enum logic [2:0] {
      IDLE,
      REDUCE,
      SQR,
      MUL,
      FINISH
   } state_t;

   function automatic int latency(input int kw);
      return kw * (2 * kw + 1) + 1;
   endfunction

endpackage

// File: rtl/dh_modmul.sv
// Bit-serial interleaved modular multiplier, MSB first over a.
// One step per cycle; done flags the final step, whose result is on r.
module dh_modmul #(
   parameter int KEY_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [KEY_W-1:0] a,
   input  logic [KEY_W-1:0] b,
   input  logic [KEY_W-1:0] p,
   output logic             done,
   output logic [KEY_W-1:0] r
);

   localparam int CW = $clog2(KEY_W);

   logic [KEY_W-1:0] a_q, b_q, p_q, r_q;
   logic [CW-1:0]    cnt;
   logic             run;
   logic [KEY_W+1:0] pe, t0, t1, t2;
   logic [1:0]       unused_hi;

   // 2r + b < 3p, so two conditional subtractions restore r < p
   always_comb begin
      pe = {2'b00, p_q};
      t0 = {1'b0, r_q, 1'b0}
         + (a_q[KEY_W-1] ? {2'b00, b_q} : '0);
      t1 = (t0 >= pe) ? t0 - pe : t0;
      t2 = (t1 >= pe) ? t1 - pe : t1;
      r  = t2[KEY_W-1:0];
      unused_hi = t2[KEY_W+1:KEY_W];
      done = run && (cnt == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q <= '0;
         b_q <= '0;
         p_q <= '0;
         r_q <= '0;
         cnt <= '0;
         run <= 1'b0;
      end else if (start) begin
         a_q <= a;
         b_q <= b;
         p_q <= p;
         r_q <= '0;
         cnt <= CW'(KEY_W - 1);
         run <= 1'b1;
      end else if (run) begin
         r_q <= r;
         a_q <= a_q << 1;
         if (cnt == '0) run <= 1'b0;
         else           cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/dh_modexp_cipher.sv
// Constant-time base^exp mod p followed by the XOR check-and-encrypt step.
module dh_modexp_cipher
   import dh_pkg::*;
#(
   parameter int DATA_W = DATA_W_D,
   parameter int KEY_W  = KEY_W_D
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] base,
   input  logic [KEY_W-1:0]  exp,
   input  logic [KEY_W-1:0]  p,
   input  logic [DATA_W-1:0] c1,
   input  logic [DATA_W-1:0] r1,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] key_out,
   output logic              valid_c2,
   output logic [DATA_W-1:0] c2
);

   localparam int IW = $clog2(KEY_W);

   state_t            state;
   logic [DATA_W-1:0] base_q, c1_q, r1_q;
   logic [KEY_W-1:0]  exp_q, p_q, b_q, acc;
   logic [IW-1:0]     idx;
   logic              err_q;

   logic              mm_start, mm_done;
   logic [KEY_W-1:0]  mm_a, mm_b, mm_p, mm_r, acc_nxt;
   logic [DATA_W-1:0] key_fin, r2n;
   logic              v_fin;

   dh_modmul #(.KEY_W(KEY_W)) u_mul (
      .clk   (clk),
      .rst   (rst),
      .start (mm_start),
      .a     (mm_a),
      .b     (mm_b),
      .p     (mm_p),
      .done  (mm_done),
      .r     (mm_r)
   );

   // Next multiply is launched on the edge that retires the current one
   always_comb begin
      mm_start = 1'b0;
      mm_a     = acc;
      mm_b     = acc;
      mm_p     = p_q;
      acc_nxt  = exp_q[idx] ? mm_r : acc;
      unique case (state)
         IDLE: begin
            mm_p     = p;
            mm_a     = KEY_W'(base);
            mm_b     = KEY_W'(1);
            mm_start = start && (p >= KEY_W'(2));
         end
         REDUCE: begin
            mm_a     = KEY_W'(1);
            mm_b     = KEY_W'(1);
            mm_start = mm_done;
         end
         SQR: begin
            mm_a     = mm_r;
            mm_b     = b_q;
            mm_start = mm_done;
         end
         MUL: begin
            mm_a     = acc_nxt;
            mm_b     = acc_nxt;
            mm_start = mm_done && (idx != '0);
         end
         default: ;
      endcase
   end

   always_comb begin
      key_fin = acc[DATA_W-1:0];
      r2n     = key_fin ^ c1_q;
      v_fin   = !err_q && (r2n != base_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         base_q   <= '0;
         c1_q     <= '0;
         r1_q     <= '0;
         exp_q    <= '0;
         p_q      <= '0;
         b_q      <= '0;
         acc      <= '0;
         idx      <= '0;
         err_q    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         key_out  <= '0;
         valid_c2 <= 1'b0;
         c2       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  base_q <= base;
                  c1_q   <= c1;
                  r1_q   <= r1;
                  exp_q  <= exp;
                  p_q    <= p;
                  acc    <= '0;
                  if (p < KEY_W'(2)) begin
                     err_q <= 1'b1;
                     state <= FINISH;
                  end else begin
                     err_q <= 1'b0;
                     busy  <= 1'b1;
                     state <= REDUCE;
                  end
               end
            end
            REDUCE: if (mm_done) begin
               b_q   <= mm_r;
               acc   <= KEY_W'(1);
               idx   <= IW'(KEY_W - 1);
               state <= SQR;
            end
            SQR: if (mm_done) begin
               acc   <= mm_r;
               state <= MUL;
            end
            MUL: if (mm_done) begin
               acc <= acc_nxt;
               if (idx == '0) begin
                  state <= FINISH;
               end else begin
                  idx   <= idx - 1'b1;
                  state <= SQR;
               end
            end
            FINISH: begin
               done     <= 1'b1;
               busy     <= 1'b0;
               err      <= err_q;
               key_out  <= err_q ? '0 : key_fin;
               valid_c2 <= v_fin;
               c2       <= v_fin ? (key_fin ^ r1_q) : '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
